// File: rtl/stack_cache_pkg.sv
// Shared types and line-window helpers for the stack cache ring controller.
package stack_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVICT_WB,
        ST_FETCH,
        ST_WAIT_RESP
    } fsm_e;

    typedef struct packed {
        logic valid;
        logic pending;
        logic dirty;
    } slot_st_t;

    // Offset k (relative to the head line) of the idx-th line fetched after a new SP.
    function automatic int fill_k(input int idx, input int push_ahead, input logic prepop);
        if (prepop) return push_ahead + 1 - idx;
        if (idx <= push_ahead) return idx;
        return push_ahead - idx;
    endfunction

    function automatic int push_victim_k(input int push_ahead, input logic prepop);
        return push_ahead + (prepop ? 1 : 0);
    endfunction

    function automatic int pop_victim_k(input int pop_depth, input logic prepop);
        return -(pop_depth - (prepop ? 1 : 0));
    endfunction

endpackage

// File: rtl/stack_cache_bound_chk.sv
// Combinational test of base+offset line address against the legal line range, without wrap.
module stack_cache_bound_chk #(
    parameter int LADDR_W = 12,
    parameter int KW      = 4
) (
    input  logic [LADDR_W-1:0]   base_laddr_i,
    input  logic signed [KW-1:0] offset_i,
    input  logic [LADDR_W-1:0]   lower_laddr_i,
    input  logic [LADDR_W-1:0]   upper_laddr_i,
    output logic [LADDR_W-1:0]   cand_laddr_o,
    output logic                 in_bounds_o
);

    // Two guard bits: the top one flags a result below zero.
    logic [LADDR_W+1:0] sum;

    assign sum          = {2'b00, base_laddr_i} + {{(LADDR_W+2-KW){offset_i[KW-1]}}, offset_i};
    assign cand_laddr_o = sum[LADDR_W-1:0];
    assign in_bounds_o  = !sum[LADDR_W+1]
                        && (sum[LADDR_W:0] >= {1'b0, lower_laddr_i})
                        && (sum[LADDR_W:0] <= {1'b0, upper_laddr_i});

endmodule

// File: rtl/stack_cache_ring_ctrl.sv
// Ring-window line controller for the stack cache: head tracking, victim write-back/refill sequencing.
// Optional macro STACKCACHE_PREPOP_EN adds cfg_prepop (window shifted one line toward push on sp_new).
module stack_cache_ring_ctrl
    import stack_cache_pkg::*;
#(
    parameter  int LINES      = 4,
    parameter  int PUSH_AHEAD = 1,
    parameter  int LINE_BYTES = 16,
    parameter  int ADDR_W     = 16,
    localparam int OFF_W      = $clog2(LINE_BYTES),
    localparam int LADDR_W    = ADDR_W - OFF_W,
    localparam int SLOT_W     = $clog2(LINES)
) (
    input  logic               clk,
    input  logic               clk_en,
    input  logic               sync_rst,
`ifdef STACKCACHE_PREPOP_EN
    input  logic               cfg_prepop,
`endif
    input  logic               sp_new_valid,
    input  logic [ADDR_W-1:0]  sp_new,
    input  logic               push_cross,
    input  logic               pop_cross,
    output logic               event_ready,
    input  logic [ADDR_W-1:0]  bound_upper,
    input  logic [ADDR_W-1:0]  bound_lower,
    input  logic               dirty_set_valid,
    input  logic [SLOT_W-1:0]  dirty_set_slot,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic               mem_req_write,
    output logic [LADDR_W-1:0] mem_req_laddr,
    output logic [SLOT_W-1:0]  mem_req_slot,
    input  logic               mem_resp_valid,
    output logic [SLOT_W-1:0]  head_slot,
    output logic [LADDR_W-1:0] head_laddr,
    output logic [LINES-1:0]   slot_valid,
    output logic               busy,
    output logic               overflow_fault,
    output logic               underflow_fault
);

    localparam int POP_DEPTH = LINES - 1 - PUSH_AHEAD;
    localparam int KW        = SLOT_W + 2;

    fsm_e                    state_q, state_d;
    slot_st_t [LINES-1:0]    st_q, st_d;
    logic [LADDR_W-1:0]      tag_q [LINES];
    logic [SLOT_W-1:0]       head_slot_q, head_slot_d;
    logic [LADDR_W-1:0]      head_laddr_q, head_laddr_d;
    logic                    reload_q, reload_d;
    logic signed [KW-1:0]    shift_k_q, shift_k_d;
    logic [SLOT_W:0]         idx_q, idx_d;
    logic [SLOT_W-1:0]       req_slot_q, req_slot_d;
    logic                    req_write_q, req_write_d;
    logic                    ex_q, ex_d;
    logic                    ovf_q, ovf_d, unf_q, unf_d;
    logic                    tag_we;

    logic                    prepop_in;
    logic [LADDR_W-1:0]      upper_line, lower_line, cand_laddr;
    logic signed [KW-1:0]    cur_k, chk_off, ev_push_off, ev_pop_off;
    logic [SLOT_W-1:0]       cur_slot, ev_slot, low_dirty;
    logic                    in_bounds, any_dirty;
    logic [LINES-1:0]        dirty_vec;
    logic                    unused_bits;

`ifdef STACKCACHE_PREPOP_EN
    assign prepop_in = cfg_prepop;
`else
    assign prepop_in = 1'b0;
`endif

    assign upper_line  = bound_upper[ADDR_W-1:OFF_W];
    assign lower_line  = bound_lower[ADDR_W-1:OFF_W];
    assign unused_bits = ^{bound_upper[OFF_W-1:0], bound_lower[OFF_W-1:0], sp_new[OFF_W-1:0]};

    // Event offsets are relative to the pre-move head, so they are one step beyond the victim k.
    assign ev_push_off = KW'(push_victim_k(PUSH_AHEAD, ex_q) + 1);
    assign ev_pop_off  = KW'(pop_victim_k(POP_DEPTH, ex_q) - 1);
    assign cur_k       = reload_q ? KW'(fill_k(int'(idx_q), PUSH_AHEAD, ex_q)) : shift_k_q;
    assign chk_off     = (state_q == ST_IDLE) ? (push_cross ? ev_push_off : ev_pop_off) : cur_k;
    assign ev_slot     = head_slot_q + chk_off[SLOT_W-1:0];
    assign cur_slot    = head_slot_q + cur_k[SLOT_W-1:0];

    stack_cache_bound_chk #(.LADDR_W(LADDR_W), .KW(KW)) u_bound_chk (
        .base_laddr_i  (head_laddr_q),
        .offset_i      (chk_off),
        .lower_laddr_i (lower_line),
        .upper_laddr_i (upper_line),
        .cand_laddr_o  (cand_laddr),
        .in_bounds_o   (in_bounds)
    );

    // A write-back completing this cycle no longer counts as dirty when picking the next one.
    always_comb begin
        any_dirty = 1'b0;
        low_dirty = '0;
        for (int i = 0; i < LINES; i++) begin
            dirty_vec[i] = st_q[i].dirty
                         && !(state_q == ST_WAIT_RESP && req_write_q && req_slot_q == SLOT_W'(i));
        end
        for (int i = LINES - 1; i >= 0; i--) begin
            if (dirty_vec[i]) begin
                any_dirty = 1'b1;
                low_dirty = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        st_d         = st_q;
        head_slot_d  = head_slot_q;
        head_laddr_d = head_laddr_q;
        reload_d     = reload_q;
        shift_k_d    = shift_k_q;
        idx_d        = idx_q;
        req_slot_d   = req_slot_q;
        req_write_d  = req_write_q;
        ex_d         = ex_q;
        ovf_d        = 1'b0;
        unf_d        = 1'b0;
        tag_we       = 1'b0;

        if (dirty_set_valid && !st_q[dirty_set_slot].pending) begin
            st_d[dirty_set_slot].dirty = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (sp_new_valid) begin
                    reload_d     = 1'b1;
                    idx_d        = '0;
                    ex_d         = prepop_in;
                    head_slot_d  = '0;
                    head_laddr_d = sp_new[ADDR_W-1:OFF_W];
                    for (int i = 0; i < LINES; i++) begin
                        st_d[i].valid   = 1'b0;
                        st_d[i].pending = 1'b0;
                    end
                    req_slot_d = low_dirty;
                    state_d    = any_dirty ? ST_EVICT_WB : ST_FETCH;
                end else if (push_cross) begin
                    if (head_laddr_q >= upper_line) begin
                        ovf_d = 1'b1;
                    end else begin
                        head_slot_d         = head_slot_q + SLOT_W'(1);
                        head_laddr_d        = head_laddr_q + LADDR_W'(1);
                        reload_d            = 1'b0;
                        shift_k_d           = KW'(push_victim_k(PUSH_AHEAD, ex_q));
                        req_slot_d          = ev_slot;
                        st_d[ev_slot].valid = 1'b0;
                        if (in_bounds) begin
                            state_d = st_d[ev_slot].dirty ? ST_EVICT_WB : ST_FETCH;
                        end else begin
                            st_d[ev_slot].dirty = 1'b0;
                        end
                    end
                end else if (pop_cross) begin
                    if (head_laddr_q <= lower_line) begin
                        unf_d = 1'b1;
                    end else begin
                        head_slot_d         = head_slot_q - SLOT_W'(1);
                        head_laddr_d        = head_laddr_q - LADDR_W'(1);
                        reload_d            = 1'b0;
                        shift_k_d           = KW'(pop_victim_k(POP_DEPTH, ex_q));
                        req_slot_d          = ev_slot;
                        st_d[ev_slot].valid = 1'b0;
                        if (in_bounds) begin
                            state_d = st_d[ev_slot].dirty ? ST_EVICT_WB : ST_FETCH;
                        end else begin
                            st_d[ev_slot].dirty = 1'b0;
                        end
                    end
                end
            end
            ST_EVICT_WB: begin
                if (mem_req_ready) begin
                    req_write_d = 1'b1;
                    state_d     = ST_WAIT_RESP;
                end
            end
            ST_FETCH: begin
                if (!in_bounds) begin
                    // Out-of-range window line: leave its slot invalid and move on.
                    idx_d = idx_q + (SLOT_W+1)'(1);
                    if (!reload_q || idx_q == (SLOT_W+1)'(LINES - 1)) state_d = ST_IDLE;
                end else if (mem_req_ready) begin
                    st_d[cur_slot].pending = 1'b1;
                    st_d[cur_slot].dirty   = 1'b0;
                    tag_we                 = 1'b1;
                    req_slot_d             = cur_slot;
                    req_write_d            = 1'b0;
                    state_d                = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (mem_resp_valid) begin
                    if (req_write_q) begin
                        st_d[req_slot_q].dirty = 1'b0;
                        if (reload_q && any_dirty) begin
                            req_slot_d = low_dirty;
                            state_d    = ST_EVICT_WB;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end else begin
                        st_d[req_slot_q].valid   = 1'b1;
                        st_d[req_slot_q].pending = 1'b0;
                        if (reload_q && idx_q != (SLOT_W+1)'(LINES - 1)) begin
                            idx_d   = idx_q + (SLOT_W+1)'(1);
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q      <= ST_IDLE;
            st_q         <= '0;
            head_slot_q  <= '0;
            head_laddr_q <= '0;
            reload_q     <= 1'b0;
            shift_k_q    <= '0;
            idx_q        <= '0;
            req_slot_q   <= '0;
            req_write_q  <= 1'b0;
            ex_q         <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else if (clk_en) begin
            state_q      <= state_d;
            st_q         <= st_d;
            head_slot_q  <= head_slot_d;
            head_laddr_q <= head_laddr_d;
            reload_q     <= reload_d;
            shift_k_q    <= shift_k_d;
            idx_q        <= idx_d;
            req_slot_q   <= req_slot_d;
            req_write_q  <= req_write_d;
            ex_q         <= ex_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en && tag_we) tag_q[cur_slot] <= cand_laddr;
    end

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_laddr = '0;
        mem_req_slot  = '0;
        if (state_q == ST_EVICT_WB) begin
            mem_req_valid = 1'b1;
            mem_req_write = 1'b1;
            mem_req_laddr = tag_q[req_slot_q];
            mem_req_slot  = req_slot_q;
        end else if (state_q == ST_FETCH) begin
            mem_req_valid = in_bounds;
            mem_req_laddr = cand_laddr;
            mem_req_slot  = cur_slot;
        end
        for (int i = 0; i < LINES; i++) slot_valid[i] = st_q[i].valid;
    end

    assign busy            = (state_q != ST_IDLE);
    assign event_ready     = !busy;
    assign head_slot       = head_slot_q;
    assign head_laddr      = head_laddr_q;
    assign overflow_fault  = ovf_q;
    assign underflow_fault = unf_q;

endmodule

// File: tb/tb_stack_cache_ring_ctrl.sv
// Directed bench for stack_cache_ring_ctrl with a request scoreboard and a simple memory responder.
module tb_stack_cache_ring_ctrl;

    logic        clk = 1'b0;
    logic        clk_en, sync_rst, sp_new_valid, push_cross, pop_cross, event_ready;
    logic [15:0] sp_new, bound_upper, bound_lower;
    logic        dirty_set_valid;
    logic [1:0]  dirty_set_slot;
    logic        mem_req_valid, mem_req_ready, mem_req_write, mem_resp_valid;
    logic [11:0] mem_req_laddr, head_laddr;
    logic [1:0]  mem_req_slot, head_slot;
    logic [3:0]  slot_valid;
    logic        busy, overflow_fault, underflow_fault;

    typedef struct packed {
        logic        wr;
        logic [11:0] laddr;
        logic [1:0]  slot;
    } req_t;

    req_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    stack_cache_ring_ctrl dut (
        .clk             (clk),
        .clk_en          (clk_en),
        .sync_rst        (sync_rst),
`ifdef STACKCACHE_PREPOP_EN
        .cfg_prepop      (1'b0),
`endif
        .sp_new_valid    (sp_new_valid),
        .sp_new          (sp_new),
        .push_cross      (push_cross),
        .pop_cross       (pop_cross),
        .event_ready     (event_ready),
        .bound_upper     (bound_upper),
        .bound_lower     (bound_lower),
        .dirty_set_valid (dirty_set_valid),
        .dirty_set_slot  (dirty_set_slot),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_write   (mem_req_write),
        .mem_req_laddr   (mem_req_laddr),
        .mem_req_slot    (mem_req_slot),
        .mem_resp_valid  (mem_resp_valid),
        .head_slot       (head_slot),
        .head_laddr      (head_laddr),
        .slot_valid      (slot_valid),
        .busy            (busy),
        .overflow_fault  (overflow_fault),
        .underflow_fault (underflow_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_req(input logic wr, input logic [11:0] laddr, input logic [1:0] slot);
        req_t e;
        e.wr    = wr;
        e.laddr = laddr;
        e.slot  = slot;
        exp_q.push_back(e);
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!mem_req_valid && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic serve_one();
        req_t e;
        wait_req();
        e = exp_q.pop_front();
        if (!mem_req_valid) begin
            check("req_timeout", {31'd0, mem_req_valid}, 32'd1);
            return;
        end
        check("req_write", {31'd0, mem_req_write}, {31'd0, e.wr});
        check("req_laddr", {20'd0, mem_req_laddr}, {20'd0, e.laddr});
        check("req_slot",  {30'd0, mem_req_slot},  {30'd0, e.slot});
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
    endtask

    task automatic drain();
        while (exp_q.size() != 0) serve_one();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk_en          = 1'b1;
        sync_rst        = 1'b1;
        sp_new_valid    = 1'b0;
        sp_new          = '0;
        push_cross      = 1'b0;
        pop_cross       = 1'b0;
        bound_upper     = 16'h10FF;
        bound_lower     = 16'h1000;
        dirty_set_valid = 1'b0;
        dirty_set_slot  = '0;
        mem_req_ready   = 1'b0;
        mem_resp_valid  = 1'b0;
        tick();
        tick();
        sync_rst = 1'b0;
        tick();

        // Reset state
        check("rst_busy",        {31'd0, busy}, 32'd0);
        check("rst_event_ready", {31'd0, event_ready}, 32'd1);
        check("rst_slot_valid",  {28'd0, slot_valid}, 32'd0);
        check("rst_head_slot",   {30'd0, head_slot}, 32'd0);
        check("rst_head_laddr",  {20'd0, head_laddr}, 32'd0);
        check("rst_req_valid",   {31'd0, mem_req_valid}, 32'd0);
        check("rst_faults",      {30'd0, overflow_fault, underflow_fault}, 32'd0);

        // New SP in the middle of the range
        sp_new       = 16'h1050;
        sp_new_valid = 1'b1;
        tick();
        sp_new_valid = 1'b0;
        check("sp1_busy",       {31'd0, busy}, 32'd1);
        check("sp1_head_laddr", {20'd0, head_laddr}, 32'h105);
        expect_req(1'b0, 12'h105, 2'd0);
        expect_req(1'b0, 12'h106, 2'd1);
        expect_req(1'b0, 12'h104, 2'd3);
        expect_req(1'b0, 12'h103, 2'd2);
        drain();
        wait_idle("sp1_idle");
        check("sp1_head_slot",  {30'd0, head_slot}, 32'd0);
        check("sp1_slot_valid", {28'd0, slot_valid}, 32'hF);

        // Push with a dirty victim (slot 2 holds line 0x103), memory stalls 5 cycles
        dirty_set_valid = 1'b1;
        dirty_set_slot  = 2'd2;
        tick();
        dirty_set_valid = 1'b0;
        push_cross = 1'b1;
        tick();
        push_cross = 1'b0;
        check("push_head_laddr", {20'd0, head_laddr}, 32'h106);
        check("push_head_slot",  {30'd0, head_slot}, 32'd1);
        check("push_slot_valid", {28'd0, slot_valid}, 32'hB);
        check("push_event_rdy",  {31'd0, event_ready}, 32'd0);
        expect_req(1'b1, 12'h103, 2'd2);
        expect_req(1'b0, 12'h107, 2'd2);
        wait_req();
        repeat (5) tick();
        check("stall_valid", {31'd0, mem_req_valid}, 32'd1);
        check("stall_write", {31'd0, mem_req_write}, 32'd1);
        check("stall_laddr", {20'd0, mem_req_laddr}, 32'h103);
        check("stall_slot",  {30'd0, mem_req_slot}, 32'd2);
        drain();
        wait_idle("push_idle");
        check("push_slot_valid_end", {28'd0, slot_valid}, 32'hF);

        // Clock enable low: a push is ignored
        clk_en     = 1'b0;
        push_cross = 1'b1;
        tick();
        tick();
        push_cross = 1'b0;
        clk_en     = 1'b1;
        tick();
        check("clken_head_laddr", {20'd0, head_laddr}, 32'h106);
        check("clken_busy",       {31'd0, busy}, 32'd0);

        // Pop: victim slot 2 refilled with line 0x103
        pop_cross = 1'b1;
        tick();
        pop_cross = 1'b0;
        check("pop_head_laddr", {20'd0, head_laddr}, 32'h105);
        check("pop_head_slot",  {30'd0, head_slot}, 32'd0);
        expect_req(1'b0, 12'h103, 2'd2);
        drain();
        wait_idle("pop_idle");

        // New SP near the top with dirty slots 3 and 1: ascending write-backs, top line skipped
        dirty_set_valid = 1'b1;
        dirty_set_slot  = 2'd3;
        tick();
        dirty_set_slot  = 2'd1;
        tick();
        dirty_set_valid = 1'b0;
        sp_new       = 16'h10F8;
        sp_new_valid = 1'b1;
        tick();
        sp_new_valid = 1'b0;
        check("sp2_slot_valid_inv", {28'd0, slot_valid}, 32'h0);
        expect_req(1'b1, 12'h106, 2'd1);
        expect_req(1'b1, 12'h104, 2'd3);
        expect_req(1'b0, 12'h10F, 2'd0);
        expect_req(1'b0, 12'h10E, 2'd3);
        expect_req(1'b0, 12'h10D, 2'd2);
        drain();
        wait_idle("sp2_idle");
        check("sp2_slot_valid", {28'd0, slot_valid}, 32'hD);

        push_cross = 1'b1;
        tick();
        push_cross = 1'b0;
        check("ovf_pulse",      {31'd0, overflow_fault}, 32'd1);
        check("ovf_busy",       {31'd0, busy}, 32'd0);
        check("ovf_head_laddr", {20'd0, head_laddr}, 32'h10F);
        tick();
        check("ovf_pulse_end",  {31'd0, overflow_fault}, 32'd0);

        // New SP at the bottom: pop side out of range, then underflow
        sp_new       = 16'h1000;
        sp_new_valid = 1'b1;
        tick();
        sp_new_valid = 1'b0;
        expect_req(1'b0, 12'h100, 2'd0);
        expect_req(1'b0, 12'h101, 2'd1);
        drain();
        wait_idle("sp3_idle");
        check("sp3_slot_valid", {28'd0, slot_valid}, 32'h3);
        pop_cross = 1'b1;
        tick();
        pop_cross = 1'b0;
        check("unf_pulse",      {31'd0, underflow_fault}, 32'd1);
        check("unf_head_laddr", {20'd0, head_laddr}, 32'h100);
        check("unf_req_valid",  {31'd0, mem_req_valid}, 32'd0);
        tick();
        check("unf_pulse_end",  {31'd0, underflow_fault}, 32'd0);

        // Reset while waiting for a fetch response, then a late response
        sp_new       = 16'h1050;
        sp_new_valid = 1'b1;
        tick();
        sp_new_valid = 1'b0;
        wait_req();
        check("rstw_req_laddr", {20'd0, mem_req_laddr}, 32'h105);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        tick();
        check("rstw_slot_valid", {28'd0, slot_valid}, 32'h0);
        check("rstw_busy",       {31'd0, busy}, 32'd0);
        check("rstw_req_valid",  {31'd0, mem_req_valid}, 32'd0);
        check("rstw_head_laddr", {20'd0, head_laddr}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
